// File: rtl/ptp_core.sv
// ptp_core: four-stage pipelined Tangled integer core.
// Interlocked register reads, no forwarding; halt freezes the machine.
module ptp_core #(
    parameter logic [15:0] NOP = 16'hF000
) (
    input  logic clk,
    input  logic reset,
    output logic halt
);
    logic [15:0] text [0:65535];
    logic [15:0] data [0:65535];
    logic [15:0] r [0:15];
    logic [15:0] pc;
    logic [15:0] stage1to2ir, stage1to2pc;
    logic [15:0] stage2to3ir, stage2to3pc;
    logic [15:0] stage2to3dv, stage2to3sv;
    logic [15:0] stage3to4ir, stage3to4res;

    function automatic logic writes(input logic [15:0] ir);
        logic [3:0] f;
        f = ir[3:0];
        case (ir[15:12])
            4'h8, 4'h9: return 1'b1;
            4'h6:       return (f <= 4'd11) && (f != 4'd9);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic reads_d(input logic [15:0] ir);
        logic [3:0] f;
        f = ir[3:0];
        case (ir[15:12])
            4'h9, 4'hA, 4'hB: return 1'b1;
            4'h6:    return (f <= 4'd12) && (f != 4'd7) && (f != 4'd8);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_s(input logic [15:0] ir);
        return (ir[15:12] == 4'h6) && (ir[3:0] <= 4'd9);
    endfunction

    function automatic logic hazard(input logic [15:0] rd,
                                    input logic [15:0] wr);
        logic hit_d, hit_s;
        hit_d = reads_d(rd) && (wr[11:8] == rd[11:8]);
        hit_s = reads_s(rd) && (wr[11:8] == rd[7:4]);
        return writes(wr) && (hit_d || hit_s);
    endfunction

    logic stall;
    assign stall = hazard(stage1to2ir, stage2to3ir)
                || hazard(stage1to2ir, stage3to4ir);

    logic [15:0] dv, sv, negs, res, target;
    logic        redirect, is_sys, is_store;

    always_comb begin
        dv       = stage2to3dv;
        sv       = stage2to3sv;
        negs     = -stage2to3sv;
        res      = 16'h0000;
        target   = stage2to3pc + 16'd1
                 + {{8{stage2to3ir[7]}}, stage2to3ir[7:0]};
        redirect = 1'b0;
        is_sys   = (stage2to3ir == 16'h0000);
        is_store = (stage2to3ir[15:12] == 4'h6)
                && (stage2to3ir[3:0] == 4'd9);
        case (stage2to3ir[15:12])
            4'h8: res = {{8{stage2to3ir[7]}}, stage2to3ir[7:0]};
            4'h9: res = {stage2to3ir[7:0], dv[7:0]};
            4'hA: redirect = (dv == 16'h0000);
            4'hB: redirect = (dv != 16'h0000);
            4'h6: begin
                case (stage2to3ir[3:0])
                    4'd0:  res = dv + sv;
                    4'd1:  res = dv & sv;
                    4'd2:  res = dv | sv;
                    4'd3:  res = dv ^ sv;
                    4'd4:  res = {15'b0, $signed(dv) < $signed(sv)};
                    4'd5: begin
                        // signed amount: left for positive, arithmetic right for negative
                        if (!sv[15])
                            res = (sv > 16'd15) ? 16'h0000 : dv << sv[3:0];
                        else if ($signed(sv) < -16'sd15)
                            res = {16{dv[15]}};
                        else
                            res = $signed(dv) >>> negs[3:0];
                    end
                    4'd6:  res = dv * sv;
                    4'd7:  res = sv;
                    4'd8:  res = data[sv];
                    4'd10: res = -dv;
                    4'd11: res = ~dv;
                    4'd12: begin
                        redirect = 1'b1;
                        target   = dv;
                    end
                    default: res = 16'h0000;
                endcase
            end
            default: res = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= 16'h0000;
            halt         <= 1'b0;
            stage1to2ir  <= NOP;
            stage1to2pc  <= 16'h0000;
            stage2to3ir  <= NOP;
            stage2to3pc  <= 16'h0000;
            stage2to3dv  <= 16'h0000;
            stage2to3sv  <= 16'h0000;
            stage3to4ir  <= NOP;
            stage3to4res <= 16'h0000;
        end else if (!halt) begin
            if (writes(stage3to4ir))
                r[stage3to4ir[11:8]] <= stage3to4res;
            if (is_store)
                data[sv] <= dv;
            stage3to4ir  <= stage2to3ir;
            stage3to4res <= res;
            if (is_sys) begin
                halt        <= 1'b1;
                stage1to2ir <= NOP;
                stage2to3ir <= NOP;
                stage3to4ir <= NOP;
            end else if (redirect) begin
                pc          <= target;
                stage1to2ir <= NOP;
                stage2to3ir <= NOP;
            end else if (stall) begin
                stage2to3ir <= NOP;
            end else begin
                pc          <= pc + 16'd1;
                stage1to2ir <= text[pc];
                stage1to2pc <= pc;
                stage2to3ir <= stage1to2ir;
                stage2to3pc <= stage1to2pc;
                stage2to3dv <= r[stage1to2ir[11:8]];
                stage2to3sv <= r[stage1to2ir[7:4]];
            end
        end
    end
endmodule

// File: tb/tb_ptp_core.sv
// tb_ptp_core: runs small programs on ptp_core to halt and
// compares final register/memory state against queued expectations.
module tb_ptp_core;
    localparam logic [15:0] N = 16'hF000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic halt;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        string       nm;
        int          mem;
        int          idx;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        string       nm;
        logic [3:0]  f;
        logic [15:0] d;
        logic [15:0] s;
        logic [15:0] q;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    ptp_core dut (.clk(clk), .reset(reset), .halt(halt));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic exp_r(input string nm, input int idx,
                         input logic [15:0] v);
        exp_t e;
        e.nm = nm; e.mem = 0; e.idx = idx; e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_m(input string nm, input int idx,
                         input logic [15:0] v);
        exp_t e;
        e.nm = nm; e.mem = 1; e.idx = idx; e.val = v;
        sb.push_back(e);
    endtask

    task automatic addv(input string nm, input logic [3:0] f,
                        input logic [15:0] d, input logic [15:0] s,
                        input logic [15:0] q);
        vec_t v;
        v.nm = nm; v.f = f; v.d = d; v.s = s; v.q = q;
        tbl.push_back(v);
    endtask

    task automatic load(input logic [15:0] p[8]);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) dut.text[i] = N;
        for (int i = 0; i < 8; i++) dut.text[i] = p[i];
    endtask

    task automatic go();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(input string nm, output int edges);
        exp_t        e;
        logic [15:0] act;
        edges = 0;
        while (halt !== 1'b1 && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({nm, " halt"}, {15'b0, halt}, 16'h0001);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.mem ? dut.data[e.idx] : dut.r[e.idx];
            check(e.nm, act, e.val);
        end
    endtask

    function automatic logic [15:0] model(input logic [3:0] f,
                                          input logic [15:0] d,
                                          input logic [15:0] s);
        logic [31:0] m;
        m = d * s;
        case (f)
            4'd0:    return d + s;
            4'd1:    return d & s;
            4'd2:    return d | s;
            4'd3:    return d ^ s;
            4'd6:    return m[15:0];
            4'd10:   return 16'h0000 - d;
            default: return ~d;
        endcase
    endfunction

    task automatic alu(input vec_t v);
        logic [15:0] p[8];
        int          n;
        p = '{{8'h81, v.d[7:0]}, {8'h91, v.d[15:8]},
              {8'h82, v.s[7:0]}, {8'h92, v.s[15:8]},
              {4'h6, 4'h1, 4'h2, v.f}, 16'h0000, N, N};
        load(p);
        exp_r(v.nm, 1, v.q);
        go();
        run(v.nm, n);
    endtask

    initial begin
        logic [15:0] p[8];
        logic [3:0]  fl[7];
        vec_t        v;
        int          n;

        addv("add", 4'd0, 16'h7FFF, 16'h0001, 16'h8000);
        addv("add_wrap", 4'd0, 16'hFFFF, 16'h0002, 16'h0001);
        addv("and", 4'd1, 16'hF0F0, 16'h3C3C, 16'h3030);
        addv("or", 4'd2, 16'hF0F0, 16'h0F01, 16'hFFF1);
        addv("xor", 4'd3, 16'hAAAA, 16'hFFFF, 16'h5555);
        addv("slt_t", 4'd4, 16'hFFFF, 16'h0001, 16'h0001);
        addv("slt_f", 4'd4, 16'h0005, 16'hFFFB, 16'h0000);
        addv("shl4", 4'd5, 16'h0001, 16'h0004, 16'h0010);
        addv("shl15", 4'd5, 16'h0003, 16'h000F, 16'h8000);
        addv("shl16", 4'd5, 16'h1234, 16'h0010, 16'h0000);
        addv("sra4", 4'd5, 16'h8000, 16'hFFFC, 16'hF800);
        addv("sra1", 4'd5, 16'h4000, 16'hFFFF, 16'h2000);
        addv("sra15", 4'd5, 16'h7FFF, 16'hFFF1, 16'h0000);
        addv("sra16", 4'd5, 16'h8001, 16'hFFF0, 16'hFFFF);
        addv("mul_ovf", 4'd6, 16'h0100, 16'h0100, 16'h0000);
        addv("mul_neg", 4'd6, 16'h0003, 16'hFFFF, 16'hFFFD);
        addv("mul", 4'd6, 16'h1234, 16'h0010, 16'h2340);
        addv("copy", 4'd7, 16'h1111, 16'hABCD, 16'hABCD);
        addv("neg", 4'd10, 16'h0005, 16'h0000, 16'hFFFB);
        addv("neg_min", 4'd10, 16'h8000, 16'h0000, 16'h8000);
        addv("not", 4'd11, 16'h00FF, 16'h0000, 16'hFF00);
        addv("alu_nop", 4'd13, 16'h1357, 16'h2468, 16'h1357);

        // reset state and first fetch
        #3;
        p = '{16'h8105, 16'h82FD, 16'h6120, 16'h0000, N, N, N, N};
        load(p);
        check("rst_pc", dut.pc, 16'h0000);
        check("rst_halt", {15'b0, halt}, 16'h0000);
        check("rst_ir", dut.stage1to2ir, 16'hF000);
        exp_r("progA_r1", 1, 16'h0002);
        exp_r("progA_r2", 2, 16'hFFFD);
        go();
        @(posedge clk);
        #1;
        check("fetch_ir", dut.stage1to2ir, 16'h8105);
        check("fetch_pc", dut.pc, 16'h0001);
        run("progA", n);

        // back-to-back dependency stalls fetch
        p = '{16'h8107, 16'h6110, 16'h0000, N, N, N, N, N};
        load(p);
        exp_r("dep_r1", 1, 16'h000E);
        go();
        repeat (4) @(posedge clk);
        #1;
        check("stall_pc", dut.pc, 16'h0002);
        check("stall_ir", dut.stage1to2ir, 16'h6110);
        run("dep", n);

        // store then load through the same address
        p = '{16'h8310, 16'h812A, 16'h6139, 16'h6438,
              16'h0000, N, N, N};
        load(p);
        dut.data[16] = 16'h0000;
        exp_m("st_data", 16, 16'h002A);
        exp_r("ld_r4", 4, 16'h002A);
        go();
        run("ldst", n);

        // brf taken skips its shadow
        p = '{16'h8500, 16'hA501, 16'h8601, 16'h8702,
              16'h0000, N, N, N};
        load(p);
        dut.r[6] = 16'h0000;
        dut.r[7] = 16'h0000;
        exp_r("brf_r6", 6, 16'h0000);
        exp_r("brf_r7", 7, 16'h0002);
        go();
        run("brf", n);

        // brf not taken
        p = '{16'h8501, 16'hA501, 16'h8604, 16'h0000, N, N, N, N};
        load(p);
        dut.r[6] = 16'h0000;
        exp_r("brf_nt_r6", 6, 16'h0004);
        go();
        run("brf_nt", n);

        // brt taken over two shadow slots
        p = '{16'h8503, 16'hB502, 16'h8601, 16'h8701,
              16'h8D07, 16'h0000, N, N};
        load(p);
        dut.r[6] = 16'h0000;
        dut.r[7] = 16'h0000;
        exp_r("brt_r6", 6, 16'h0000);
        exp_r("brt_r7", 7, 16'h0000);
        exp_r("brt_r13", 13, 16'h0007);
        go();
        run("brt", n);

        // backward branch loop counts r1 down to zero
        p = '{16'h8103, 16'h82FF, 16'h6120, 16'hB1FE,
              16'h0000, N, N, N};
        load(p);
        exp_r("loop_r1", 1, 16'h0000);
        exp_r("loop_r2", 2, 16'hFFFF);
        go();
        run("loop", n);

        // jumpr
        p = '{16'h8904, 16'h690C, 16'h8A01, 16'h8B01,
              16'h8C05, 16'h0000, N, N};
        load(p);
        dut.r[10] = 16'h0000;
        dut.r[11] = 16'h0000;
        exp_r("jr_r10", 10, 16'h0000);
        exp_r("jr_r11", 11, 16'h0000);
        exp_r("jr_r12", 12, 16'h0005);
        go();
        run("jumpr", n);

        foreach (tbl[i]) alu(tbl[i]);

        fl = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd10, 4'd11};
        for (int k = 0; k < 6; k++) begin
            v.nm = $sformatf("rnd%0d", k);
            v.f  = fl[$urandom_range(0, 6)];
            v.d  = 16'($urandom);
            v.s  = 16'($urandom);
            v.q  = model(v.f, v.d, v.s);
            alu(v);
        end

        // halt freezes the machine
        p = '{16'h0000, 16'h8809, N, N, N, N, N, N};
        load(p);
        dut.r[8] = 16'h1234;
        exp_r("frz_r8", 8, 16'h1234);
        go();
        run("freeze", n);
        check("halt_edges", 16'(n), 16'd3);
        repeat (10) @(posedge clk);
        #1;
        check("frz_pc", dut.pc, 16'h0002);
        check("frz_ir", dut.stage1to2ir, 16'hF000);
        check("frz_halt", {15'b0, halt}, 16'h0001);
        check("frz_r8b", dut.r[8], 16'h1234);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("areset_halt", {15'b0, halt}, 16'h0000);
        check("areset_pc", dut.pc, 16'h0000);
        check("areset_ir", dut.stage1to2ir, 16'hF000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ptp_core.md
Name: ptp_core

Overview:
- Pipelined Tangled processor (PTP), integer subset: 16-bit words, 16 x 16-bit registers, word-addressed 64K-word instruction and data memories held inside the block.
- Four stages:
  - Stage 1: fetch.
  - Stage 2: decode and register read.
  - Stage 3: execute, memory access, branch resolve.
  - Stage 4: writeback.
- Top-level CPU. Program and data are preloaded by the bench through internal arrays; halt is the only output.

Parameters:
- NOP, 16'hF000, bubble encoding placed in squashed or flushed pipeline slots.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- halt  output  1  high once a sys instruction has completed; the machine then freezes.

Behaviour:
- Internal names are required for bench access:
  - text[0:65535] and data[0:65535], 16-bit each.
  - r[0:15], 16-bit register file.
  - pc, 16-bit.
  - stage1to2ir, the 16-bit IR between stages 1 and 2.
- Reset (reset low, asynchronous):
  - pc=0, halt=0.
  - All pipeline IRs = NOP.
  - r, text and data are not modified.
- Encodings (d = [11:8], s = [7:4], i = [7:0]):
  - 16'h0000 sys: halt.
  - 1000 d i, lex: r[d] = sext(i).
  - 1001 d i, lhi: r[d][15:8] = i, low byte kept.
  - 1010 d i, brf: branch if r[d]==0.
  - 1011 d i, brt: branch if r[d]!=0.
  - 0110 d s f, ALU, by f:
    - 0 add: d=d+s (mod 2^16).
    - 1 and.
    - 2 or.
    - 3 xor.
    - 4 slt: d = (signed d < signed s) ? 1 : 0.
    - 5 shift: s is a signed amount. Positive shifts left; negative is an arithmetic right shift. |s|>=16 gives 0 (left) or sign fill (right).
    - 6 mul: low 16 bits.
    - 7 copy: d=s.
    - 8 load: d=data[s].
    - 9 store: data[s]=d.
    - 10 neg: d=-d.
    - 11 not: d=~d.
    - 12 jumpr: pc=r[d].
  - Every other encoding, including NOP, is a no-op.
- Branch target = (branch address + 1) + sext(i).
- Stage 1: stage1to2ir <= text[pc]; pc <= pc+1.
  - The address travels with the IR so the branch target can be computed.
- Stage 2: reads r[d] and r[s] combinationally.
  - Interlock: stall stages 1-2 (hold pc and stage1to2ir; insert NOP into stage 3) while any register read by the stage-2 instruction is the destination of a register-writing instruction in stage 3 or stage 4.
  - No forwarding and no write-through.
- Stage 3:
  - ALU result computed here.
  - load reads data combinationally; store writes data at the edge.
  - Taken brf/brt and jumpr: pc <= target, stages 1 and 2 flushed to NOP at that edge. Redirect has priority over any stall.
- Stage 4: writes r[d] at the edge for lex, lhi and ALU results other than store and jumpr.
- sys reaching stage 3:
  - At that edge halt<=1 and stages 1-2 are flushed.
  - The stage-4 instruction still writes back.
  - The sys itself has no further effect.
- While halt=1, nothing changes (pc, r, data, IRs) until reset.
- Delay between an instruction entering stage 1 and its writeback: 3 edges, not counting stalls.
- pc wraps 16'hFFFF -> 0.
- Reset mid-operation: immediate return to the reset state; partially executed instructions are discarded.

Test Plan:
- Reset low -> pc=0, halt=0, stage1to2ir=F000. After release, first rising edge -> stage1to2ir=text[0], pc=1.
- text = lex $1,5; lex $2,-3; add $1,$2 (6120); sys -> halt=1, r1=0002, r2=FFFD.
- Back-to-back dependency: lex $1,7; add $1,$1; sys -> r1=000E; stall cycles visible as stage1to2ir held.
- lex $3,0x10; lex $1,0x2A; store $1,$3; load $4,$3; sys -> data[0x10]=002A, r4=002A.
- Branch: lex $5,0; brf $5,1; lex $6,1; lex $7,2; sys with r6 preset to 0 -> r6=0 (skipped), r7=0002. Shadow instructions squashed.
- Halt freeze: sys; lex $8,9 -> halt=1, r8 unchanged. 10 further clocks change nothing. Reset low then clears halt, pc=0.
